// File: rtl/sha256_pkg.sv
// Shared types and constants for the SHA-256 message schedule datapath.
// Consumed by the schedule top and its sigma sub-module.
package sha256_pkg;

    localparam int SCHED_LEN   = 64;
    localparam int BLOCK_WORDS = 16;

    typedef logic [31:0] word_t;

    typedef enum logic [1:0] {
        IDLE,
        LOAD,
        EXPAND
    } state_t;

    function automatic word_t rotr(input word_t x, input int unsigned n);
        return (x >> n) | (x << (32 - n));
    endfunction

endpackage

// File: rtl/sha256_small_sigma.sv
// SHA-256 small sigma function, purely combinational.
// SEL=0 gives sigma0, SEL=1 gives sigma1.
module sha256_small_sigma
    import sha256_pkg::*;
#(
    parameter bit SEL = 1'b0
) (
    input  word_t x,
    output word_t y
);

    generate
        if (SEL == 1'b0) begin : g_sigma0
            assign y = rotr(x, 7) ^ rotr(x, 18) ^ (x >> 3);
        end else begin : g_sigma1
            assign y = rotr(x, 17) ^ rotr(x, 19) ^ (x >> 10);
        end
    endgenerate

endmodule

// File: rtl/sha256_msg_sched.sv
// SHA-256 message schedule: loads 16 message words, then streams W[0..63]
// through a 16-word sliding window, one word per output handshake.
module sha256_msg_sched
    import sha256_pkg::*;
#(
    parameter int NUM_WORDS = SCHED_LEN
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [31:0] in_word,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [31:0] out_word,
    output logic [5:0]  out_idx,
    output logic        busy
);

    localparam logic [5:0] LAST_IDX  = 6'(NUM_WORDS - 1);
    localparam logic [3:0] LAST_LOAD = 4'(BLOCK_WORDS - 1);

    state_t state, state_nxt;
    logic [3:0] load_cnt;
    word_t      win [BLOCK_WORDS];
    word_t      sig0, sig1, w_new;

    logic in_fire, out_fire, load_done, sched_done;

    function automatic word_t add4(input word_t a, input word_t b,
                                   input word_t c, input word_t d);
        return a + b + c + d;
    endfunction

    assign in_ready   = (state != EXPAND);
    assign busy       = (state != IDLE);
    assign in_fire    = in_valid && in_ready;
    assign out_fire   = out_valid && out_ready;
    assign load_done  = in_fire && (load_cnt == LAST_LOAD);
    assign sched_done = out_fire && (out_idx == LAST_IDX);

    // win[0] is W[t] (the word on out_word); W[t+16] needs W[t+1], W[t+9], W[t+14]
    sha256_small_sigma #(.SEL(1'b0)) u_sigma0 (.x(win[1]),  .y(sig0));
    sha256_small_sigma #(.SEL(1'b1)) u_sigma1 (.x(win[14]), .y(sig1));

    assign w_new = add4(win[0], sig0, win[9], sig1);

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (in_fire)    state_nxt = LOAD;
            LOAD:    if (load_done)  state_nxt = EXPAND;
            EXPAND:  if (sched_done) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            load_cnt  <= '0;
            out_valid <= 1'b0;
            out_idx   <= '0;
            out_word  <= '0;
        end else begin
            if (in_fire) begin
                load_cnt <= load_done ? 4'd0 : load_cnt + 4'd1;
            end
            // After the 16th shift M[0] lands in win[0]; before it, M[0] sits in win[1]
            if (load_done) begin
                out_valid <= 1'b1;
                out_idx   <= '0;
                out_word  <= win[1];
            end else if (out_fire) begin
                out_word <= win[1];
                if (sched_done) begin
                    out_valid <= 1'b0;
                end else begin
                    out_idx <= out_idx + 6'd1;
                end
            end
        end
    end

    // Window carries no reset: it is fully rewritten by every new block load
    always_ff @(posedge clk) begin
        if (in_fire || out_fire) begin
            for (int i = 0; i < BLOCK_WORDS - 1; i++) begin
                win[i] <= win[i+1];
            end
            win[BLOCK_WORDS-1] <= in_fire ? in_word : w_new;
        end
    end

endmodule

// File: tb/tb_sha256_msg_sched.sv
// Scoreboard bench for sha256_msg_sched: a reference schedule model fills the
// expectation queue per block; a negedge monitor pops on every output transfer.
module tb_sha256_msg_sched;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [31:0] in_word = '0;
    logic        out_valid;
    logic        out_ready = 1'b1;
    logic [31:0] out_word;
    logic [5:0]  out_idx;
    logic        busy;

    typedef struct {
        logic [31:0] w;
        logic [5:0]  t;
        bit          abc;
    } exp_t;

    exp_t        q[$];
    int          total = 0;
    int          bad = 0;
    bit          rdy_rand = 1'b0;
    bit          stall = 1'b0;
    logic [31:0] stall_word;
    logic [5:0]  stall_idx;

    sha256_msg_sched dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_word   (in_word),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_word  (out_word),
        .out_idx   (out_idx),
        .busy      (busy)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%08h expected=%08h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] rr(input logic [31:0] x, input int n);
        logic [63:0] d;
        d = {x, x};
        return d[n +: 32];
    endfunction

    function automatic void ref_sched(input logic [31:0] m [16], output logic [31:0] w [64]);
        for (int t = 0; t < 64; t++) begin
            if (t < 16) begin
                w[t] = m[t];
            end else begin
                w[t] = (rr(w[t-2], 17) ^ rr(w[t-2], 19) ^ (w[t-2] >> 10)) + w[t-7]
                     + (rr(w[t-15], 7) ^ rr(w[t-15], 18) ^ (w[t-15] >> 3)) + w[t-16];
            end
        end
    endfunction

    always @(posedge clk) begin
        #1;
        out_ready = rdy_rand ? 1'($urandom_range(0, 1)) : 1'b1;
    end

    always @(negedge clk) begin
        if (rst) begin
            stall = 1'b0;
        end else begin
            if (stall && out_valid) begin
                chk("stall_word", out_word, stall_word);
                chk("stall_idx", 32'(out_idx), 32'(stall_idx));
            end
            if (out_valid && out_ready) begin
                if (q.size() == 0) begin
                    chk("unexpected_out", 32'(out_idx), 32'hFFFF_FFFF);
                end else begin
                    exp_t e;
                    e = q.pop_front();
                    chk("out_word", out_word, e.w);
                    chk("out_idx", 32'(out_idx), 32'(e.t));
                    if (e.abc) begin
                        case (e.t)
                            6'd16: chk("abc_w16", out_word, 32'h61626380);
                            6'd17: chk("abc_w17", out_word, 32'h000F0000);
                            6'd18: chk("abc_w18", out_word, 32'h7DA86405);
                            6'd63: chk("abc_w63", out_word, 32'h12B1EDEB);
                            default: ;
                        endcase
                    end
                end
            end
            stall      = out_valid && !out_ready;
            stall_word = out_word;
            stall_idx  = out_idx;
        end
    end

    task automatic drive_block(input logic [31:0] m [16], input int n, input bit hold, input bit abc);
        logic [31:0] w [64];
        for (int i = 0; i < n; i++) begin
            int guard;
            guard = 0;
            in_valid = 1'b1;
            in_word  = m[i];
            while (!in_ready && guard < 500) begin
                @(posedge clk);
                #1;
                guard++;
            end
            if (!in_ready) chk("in_ready_timeout", 32'(in_ready), 32'd1);
            @(posedge clk);
            #1;
        end
        if (!hold) in_valid = 1'b0;
        if (n == 16) begin
            ref_sched(m, w);
            for (int t = 0; t < 64; t++) q.push_back('{w: w[t], t: 6'(t), abc: abc});
        end
    endtask

    task automatic drain(output int n);
        n = 0;
        while (q.size() != 0 && n < 3000) begin
            @(posedge clk);
            #1;
            n++;
        end
        if (q.size() != 0) chk("drain_timeout", 32'(q.size()), 32'd0);
        chk("post_out_valid", 32'(out_valid), 32'd0);
        chk("post_in_ready", 32'(in_ready), 32'd1);
        chk("post_busy", 32'(busy), 32'd0);
    endtask

    initial begin
        logic [31:0] abc [16];
        logic [31:0] ones [16];
        logic [31:0] rnd [16];
        int n;

        for (int i = 0; i < 16; i++) begin
            abc[i]  = 32'h0;
            ones[i] = 32'hFFFF_FFFF;
            rnd[i]  = $urandom;
        end
        abc[0]  = 32'h61626380;
        abc[15] = 32'h00000018;

        repeat (2) @(posedge clk);
        #1;
        chk("rst_in_ready", 32'(in_ready), 32'd1);
        chk("rst_out_valid", 32'(out_valid), 32'd0);
        chk("rst_out_word", out_word, 32'd0);
        chk("rst_out_idx", 32'(out_idx), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        rst = 1'b0;

        // abc block, sustained ready: 64 transfers in 64 cycles
        drive_block(abc, 16, 1'b0, 1'b1);
        chk("first_out_valid", 32'(out_valid), 32'd1);
        drain(n);
        chk("abc_cycles", 32'(n), 32'd64);

        // abc block, random backpressure
        rdy_rand = 1'b1;
        drive_block(abc, 16, 1'b0, 1'b1);
        drain(n);
        rdy_rand = 1'b0;

        // all-ones block exercises modulo-2^32 wrap
        drive_block(ones, 16, 1'b0, 1'b0);
        drain(n);

        // in_valid held high through EXPAND; next block follows immediately
        drive_block(abc, 16, 1'b1, 1'b1);
        in_word = rnd[0];
        n = 0;
        while (!in_ready && n < 500) begin
            n++;
            @(posedge clk);
            #1;
        end
        chk("hold_blocked_cycles", 32'(n), 32'd64);
        chk("hold_busy_after", 32'(busy), 32'd0);
        drive_block(rnd, 16, 1'b0, 1'b0);
        drain(n);

        // reset while W20 is on the output
        drive_block(ones, 16, 1'b0, 1'b0);
        n = 0;
        while (out_idx != 6'd20 && n < 500) begin
            @(posedge clk);
            #1;
            n++;
        end
        chk("reach_t20", 32'(out_idx), 32'd20);
        rst = 1'b1;
        q.delete();
        @(posedge clk);
        #1;
        rst = 1'b0;
        chk("midrst_out_valid", 32'(out_valid), 32'd0);
        chk("midrst_in_ready", 32'(in_ready), 32'd1);
        chk("midrst_busy", 32'(busy), 32'd0);
        chk("midrst_out_idx", 32'(out_idx), 32'd0);
        drive_block(abc, 16, 1'b0, 1'b1);
        drain(n);

        // reset coincident with the 16th load word
        drive_block(rnd, 15, 1'b1, 1'b0);
        in_word = rnd[15];
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        in_valid = 1'b0;
        chk("rst16_out_valid", 32'(out_valid), 32'd0);
        chk("rst16_busy", 32'(busy), 32'd0);
        @(posedge clk);
        #1;
        chk("rst16_out_valid_later", 32'(out_valid), 32'd0);
        drive_block(abc, 16, 1'b0, 1'b1);
        drain(n);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
